// File: rtl/score_bcd_ascii_counter.sv
`default_nettype none
// ============================================================================
// score_bcd_ascii_counter: serial saturating BCD score accumulator with ASCII view
// Revision 1.0
// ============================================================================
module score_bcd_ascii_counter #(
  parameter int N_DIGITS      = 6,
  parameter int PTS_DIGITS    = 2,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    score,
  input  logic [4*PTS_DIGITS-1:0] points,
  input  logic                    clear,
  output logic                    ready,
  output logic                    dropped,
  output logic                    overflow,
  output logic [4*N_DIGITS-1:0]   bcd_score,
  output logic [8*N_DIGITS-1:0]   asciiScore
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [N_DIGITS-1:0][3:0]  r_work;
  logic [N_DIGITS-1:0][3:0]  r_p;
  logic [N_DIGITS-1:0][3:0]  r_score;
  logic [N_DIGITS-1:0][3:0]  w_pts_clamped;
  logic [N_DIGITS-1:0][3:0]  w_commit_val;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_carry;
  logic                      r_overflow;
  logic [8*N_DIGITS-1:0]     r_ascii;
  logic [4:0]                w_sum;
  logic [4:0]                w_sum_adj;
  logic [3:0]                w_digit;
  logic                      w_carry;
  logic                      w_last;

  // Leading zeros above the most significant nonzero digit may be blanked; digit 0 never is.
  function automatic logic [8*N_DIGITS-1:0] to_ascii(input logic [N_DIGITS-1:0][3:0] d);
    logic seen;
    seen     = 1'b0;
    to_ascii = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (BLANK_LEADING && !seen && (d[i] == 4'd0) && (i != 0))
        to_ascii[8*i +: 8] = 8'h20;
      else
        to_ascii[8*i +: 8] = {4'h3, d[i]};
      if (d[i] != 4'd0) seen = 1'b1;
    end
  endfunction

  always_comb begin
    w_pts_clamped = '0;
    for (int i = 0; i < PTS_DIGITS; i++) begin
      w_pts_clamped[i] = (points[4*i +: 4] > 4'd9) ? 4'd9 : points[4*i +: 4];
    end
  end

  assign w_sum        = {1'b0, r_work[r_idx]} + {1'b0, r_p[r_idx]} + {4'd0, r_carry};
  assign w_sum_adj    = w_sum - 5'd10;
  assign w_carry      = (w_sum > 5'd9);
  assign w_digit      = w_carry ? w_sum_adj[3:0] : w_sum[3:0];
  assign w_last       = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_commit_val = r_carry ? {N_DIGITS{4'd9}} : r_work;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (score)  w_next_state = S_ADD;
      S_ADD:    if (w_last) w_next_state = S_COMMIT;
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
    if (clear) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_score    <= '0;
      r_ascii    <= to_ascii('0);
      r_overflow <= 1'b0;
      r_work     <= '0;
      r_p        <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (score) begin
            r_p     <= w_pts_clamped;
            r_work  <= r_score;
            r_idx   <= '0;
            r_carry <= 1'b0;
          end
        end
        S_ADD: begin
          r_work[r_idx] <= w_digit;
          r_carry       <= w_carry;
          r_idx         <= r_idx + IDX_W'(1);
        end
        S_COMMIT: begin
          r_score <= w_commit_val;
          r_ascii <= to_ascii(w_commit_val);
          if (r_carry) r_overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready      = (r_state == S_IDLE);
  assign dropped    = score && !ready && !clear && !reset;
  assign overflow   = r_overflow;
  assign bcd_score  = r_score;
  assign asciiScore = r_ascii;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_ascii_counter.sv
`default_nettype none
// Bench for score_bcd_ascii_counter: two instances (zero-padded and blanked ASCII) on shared stimulus.
module tb_score_bcd_ascii_counter;

  localparam int          N    = 6;
  localparam int          P    = 3;
  localparam int unsigned MAXV = 999999;

  logic           clk = 1'b0;
  logic           reset, score, clear;
  logic [4*P-1:0] points;
  logic           rdy_a, drp_a, ovf_a, rdy_b, drp_b, ovf_b;
  logic [4*N-1:0] bcd_a, bcd_b;
  logic [8*N-1:0] asc_a, asc_b;

  always #5 clk = ~clk;

  score_bcd_ascii_counter #(.N_DIGITS(N), .PTS_DIGITS(P), .BLANK_LEADING(1'b0)) dut_a (
    .clk(clk), .reset(reset), .score(score), .points(points), .clear(clear),
    .ready(rdy_a), .dropped(drp_a), .overflow(ovf_a), .bcd_score(bcd_a), .asciiScore(asc_a));

  score_bcd_ascii_counter #(.N_DIGITS(N), .PTS_DIGITS(P), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .reset(reset), .score(score), .points(points), .clear(clear),
    .ready(rdy_b), .dropped(drp_b), .overflow(ovf_b), .bcd_score(bcd_b), .asciiScore(asc_b));

  typedef struct {
    int unsigned val;
    bit          ovf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_score = 0, m_pend = 0;
  bit          m_ovf = 1'b0, m_pend_ovf = 1'b0, m_known = 1'b0;
  int          m_busy = 0;
  bit          exp_valid = 1'b0, exp_ready = 1'b1, exp_dropped = 1'b0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int unsigned pts_value(input logic [4*P-1:0] p);
    int unsigned pw = 1, sum = 0, d;
    for (int i = 0; i < P; i++) begin
      d   = int'(p[4*i +: 4]);
      sum += ((d > 9) ? 9 : d) * pw;
      pw  *= 10;
    end
    return sum;
  endfunction

  function automatic logic [4*N-1:0] exp_bcd(input int unsigned v);
    int unsigned pw = 1;
    exp_bcd = '0;
    for (int i = 0; i < N; i++) begin
      exp_bcd[4*i +: 4] = 4'((v / pw) % 10);
      pw *= 10;
    end
  endfunction

  function automatic logic [8*N-1:0] exp_ascii(input int unsigned v, input bit blank);
    int unsigned pw = 1;
    exp_ascii = '0;
    for (int i = 0; i < N; i++) begin
      exp_ascii[8*i +: 8] = (blank && i > 0 && v < pw) ? 8'h20 : 8'(8'h30 + (v / pw) % 10);
      pw *= 10;
    end
  endfunction

  // One clock of stimulus; the model advances by the effect of the coming edge.
  task automatic step(input bit r, input bit c, input bit s, input logic [4*P-1:0] p);
    exp_t        e;
    int unsigned sum;
    @(posedge clk);
    #1;
    reset = r; clear = c; score = s; points = p;
    exp_valid   = m_known;
    exp_ready   = (m_busy == 0);
    exp_dropped = s && (m_busy != 0) && !c && !r;
    if (r || c) begin
      if (m_busy != 0) void'(sb.pop_back());
      m_busy = 0; m_score = 0; m_ovf = 1'b0;
      e.val = 0; e.ovf = 1'b0;
      sb.push_back(e);
      if (r) m_known = 1'b1;
    end else if (m_busy != 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_score = m_pend;
        m_ovf   = m_pend_ovf;
      end
    end else if (s) begin
      sum        = m_score + pts_value(p);
      m_pend_ovf = m_ovf || (sum > MAXV);
      m_pend     = (sum > MAXV) ? MAXV : sum;
      m_busy     = N + 1;
      e.val = m_pend; e.ovf = m_pend_ovf;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic add(input logic [4*P-1:0] p);
    step(1'b0, 1'b0, 1'b1, p);
    idle(N + 1);
  endtask

  // Monitor: each committed/cleared score pops one expected entry.
  initial begin
    bit   prev_ready = 1'b1;
    bit   prev_clr   = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_valid) begin
        check("ready_a", 64'(rdy_a), 64'(exp_ready));
        check("ready_b", 64'(rdy_b), 64'(exp_ready));
        check("dropped", 64'(drp_a), 64'(exp_dropped));
      end
      if ((rdy_a === 1'b1 && !prev_ready) || prev_clr) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("bcd_score", 64'(bcd_a), 64'(exp_bcd(e.val)));
          check("bcd_score_b", 64'(bcd_b), 64'(exp_bcd(e.val)));
          check("ascii", 64'(asc_a), 64'(exp_ascii(e.val, 1'b0)));
          check("ascii_blank", 64'(asc_b), 64'(exp_ascii(e.val, 1'b1)));
          check("overflow", 64'(ovf_a), 64'(e.ovf));
        end
      end
      prev_ready = (rdy_a === 1'b1);
      prev_clr   = (reset === 1'b1) || (clear === 1'b1);
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; score = 1'b0; points = '0;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(2);
    add(12'h001);
    add(12'h098);
    add(12'h001);
    add(12'h000);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 12'h005);
    idle(N + 2);
    // Abort by clear in the third ADD cycle, then by reset
    step(1'b0, 1'b0, 1'b1, 12'h123);
    idle(2);
    step(1'b0, 1'b1, 1'b0, '0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 12'h777);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 12'h111);
    idle(3);
    add(12'h042);
    add(12'h00C);
    add(12'hFC0);
    step(1'b0, 1'b1, 1'b1, 12'h001);
    idle(2);
    // Fill to 999990 then saturate
    for (int i = 0; i < 1000; i++) add(12'h999);
    add(12'h990);
    add(12'h025);
    add(12'h001);
    add(12'h000);
    step(1'b0, 1'b1, 1'b0, '0);
    idle(2);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 2) == 0), 12'($urandom));
    end
    idle(N + 4);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
